// File: rtl/pipe_wb_trace_pkg.sv
// pipe_wb_trace_pkg: exception bit indices, LoongArch ecodes and the index-to-ecode lookup
package pipe_wb_trace_pkg;
    localparam int EXC_INT  = 0;
    localparam int EXC_ADEF = 1;
    localparam int EXC_SYS  = 2;
    localparam int EXC_BRK  = 3;
    localparam int EXC_INE  = 4;
    localparam int EXC_ALE  = 5;
    localparam int EXC_ADEM = 6;
    localparam logic [5:0] ECODE_INT = 6'h0;
    localparam logic [5:0] ECODE_ADE = 6'h8;
    localparam logic [5:0] ECODE_ALE = 6'h9;
    localparam logic [5:0] ECODE_SYS = 6'hB;
    localparam logic [5:0] ECODE_BRK = 6'hC;
    localparam logic [5:0] ECODE_INE = 6'hD;
    localparam logic [8:0] ESUBCODE_ADEF = 9'd0;
    localparam logic [8:0] ESUBCODE_ADEM = 9'd1;

    function automatic logic [5:0] exc_ecode(input int idx);
        return (idx == EXC_ADEF || idx == EXC_ADEM) ? ECODE_ADE :
               idx == EXC_SYS ? ECODE_SYS :
               idx == EXC_BRK ? ECODE_BRK :
               idx == EXC_INE ? ECODE_INE :
               idx == EXC_ALE ? ECODE_ALE : ECODE_INT;
    endfunction
endpackage

// File: rtl/pipe_wb_trace_fifo.sv
// wb_trace_fifo: synchronous FIFO; a push while full is accepted only alongside a pop
module wb_trace_fifo #(
    parameter int W     = 70,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] count;
    logic          do_push, do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rp];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= wp + 1'b1;
            end
            if (do_pop) rp <= rp + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/pipe_wb_trace.sv
// pipe_wb_trace: LoongArch write-back stage with prioritised exceptions and a retire trace FIFO
module pipe_wb_trace
    import pipe_wb_trace_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int CSR_NUM_W   = 14,
    parameter int NUM_EXC     = 7,
    parameter int TRACE_DEPTH = 4,
    parameter int TRACE_EN    = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 from_valid,
    output logic                 to_allowin,
    input  logic [DATA_W-1:0]    from_pc,
    input  logic                 rf_we_MEM,
    input  logic [4:0]           rf_waddr_MEM,
    input  logic [DATA_W-1:0]    rf_wdata_MEM,
    input  logic                 csr_en_MEM,
    input  logic                 csr_we_MEM,
    input  logic [CSR_NUM_W-1:0] csr_num_MEM,
    input  logic [DATA_W-1:0]    csr_wmask_MEM,
    input  logic [DATA_W-1:0]    csr_wdata_MEM,
    input  logic                 ertn_MEM,
    input  logic [2:0]           rd_cnt_op_MEM,
    input  logic [DATA_W-1:0]    rd_timer_MEM,
    input  logic [NUM_EXC-1:0]   exc_MEM,
    input  logic [DATA_W-1:0]    vaddr_MEM,
    input  logic [DATA_W-1:0]    csr_rvalue,
    output logic                 rf_we,
    output logic [4:0]           rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic                 csr_we,
    output logic [CSR_NUM_W-1:0] csr_num,
    output logic [DATA_W-1:0]    csr_wmask,
    output logic [DATA_W-1:0]    csr_wdata,
    output logic                 wb_ex,
    output logic                 ertn_flush,
    output logic [5:0]           wb_ecode,
    output logic [8:0]           wb_esubcode,
    output logic [DATA_W-1:0]    wb_vaddr,
    output logic [DATA_W-1:0]    wb_pc,
    output logic                 trace_valid,
    input  logic                 trace_pop,
    output logic [DATA_W-1:0]    trace_pc,
    output logic [DATA_W-1:0]    trace_wdata,
    output logic [4:0]           trace_waddr,
    output logic                 trace_we
);
    localparam int TW = 2 * DATA_W + 6;
    logic                 valid, ready_go, retire, exc_any, full;
    logic                 gr_we_r, csr_en_r, csr_we_r, ertn_r;
    logic [DATA_W-1:0]    wdata_r, timer_r;
    logic [2:0]           cnt_r;
    logic [NUM_EXC-1:0]   exc_r;

    assign ready_go   = ~full | trace_pop;
    assign to_allowin = ~valid | ready_go;
    assign retire     = valid & ready_go;
    assign exc_any    = |exc_r;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid     <= 1'b0;
            wb_pc     <= '0;
            gr_we_r   <= 1'b0;
            rf_waddr  <= '0;
            wdata_r   <= '0;
            csr_en_r  <= 1'b0;
            csr_we_r  <= 1'b0;
            csr_num   <= '0;
            csr_wmask <= '0;
            csr_wdata <= '0;
            ertn_r    <= 1'b0;
            cnt_r     <= '0;
            timer_r   <= '0;
            exc_r     <= '0;
            wb_vaddr  <= '0;
        end else if (to_allowin) begin
            valid <= from_valid;
            if (from_valid) begin
                wb_pc     <= from_pc;
                gr_we_r   <= rf_we_MEM;
                rf_waddr  <= rf_waddr_MEM;
                wdata_r   <= rf_wdata_MEM;
                csr_en_r  <= csr_en_MEM;
                csr_we_r  <= csr_we_MEM;
                csr_num   <= csr_num_MEM;
                csr_wmask <= csr_wmask_MEM;
                csr_wdata <= csr_wdata_MEM;
                ertn_r    <= ertn_MEM;
                cnt_r     <= rd_cnt_op_MEM;
                timer_r   <= rd_timer_MEM;
                exc_r     <= exc_MEM;
                wb_vaddr  <= vaddr_MEM;
            end
        end
    end

    // rdcntid reads the TID CSR, so it shares the CSR read path
    assign rf_wdata = (csr_en_r | cnt_r[0]) ? csr_rvalue :
                      (|cnt_r[2:1])         ? timer_r    : wdata_r;

    assign rf_we      = retire & gr_we_r & ~exc_any;
    assign csr_we     = retire & csr_we_r & ~exc_any;
    assign ertn_flush = retire & ertn_r & ~exc_any;
    assign wb_ex      = retire & exc_any;

    // Scan high to low so the lowest set bit wins; codes are never ORed
    always_comb begin
        wb_ecode    = '0;
        wb_esubcode = '0;
        for (int i = NUM_EXC - 1; i >= 0; i--)
            if (exc_r[i]) begin
                wb_ecode    = exc_ecode(i);
                wb_esubcode = (i == EXC_ADEM) ? ESUBCODE_ADEM : ESUBCODE_ADEF;
            end
    end

    if (TRACE_EN != 0) begin : g_trace
        logic [TW-1:0] head;
        logic          empty;
        wb_trace_fifo #(.W(TW), .DEPTH(TRACE_DEPTH)) u_fifo (
            .clk   (clk),
            .resetn(resetn),
            .push  (retire),
            .pop   (trace_pop),
            .din   ({wb_pc, rf_we, rf_waddr, rf_wdata}),
            .dout  (head),
            .full  (full),
            .empty (empty)
        );
        assign {trace_pc, trace_we, trace_waddr, trace_wdata} = head;
        assign trace_valid = ~empty;
    end else begin : g_no_trace
        assign full        = 1'b0;
        assign trace_valid = 1'b0;
        assign trace_pc    = '0;
        assign trace_we    = 1'b0;
        assign trace_waddr = '0;
        assign trace_wdata = '0;
    end
endmodule

// File: tb/tb_pipe_wb_trace.sv
// tb_pipe_wb_trace: directed and random stimulus against a queue-based model of the WB stage and trace
module tb_pipe_wb_trace;
    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        cen, cwe;
        logic [13:0] cnum;
        logic [31:0] cmask, cdata;
        logic        ertn;
        logic [2:0]  cnt;
        logic [31:0] timer;
        logic [6:0]  exc;
        logic [31:0] vaddr;
    } ins_t;
    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } tr_t;

    logic clk = 1'b0, resetn = 1'b0;
    always #5 clk = ~clk;

    ins_t        cur, s;
    logic        fv = 1'b0, pop = 1'b0;
    logic [31:0] crv = '0;

    logic        to_allowin, rf_we, csr_we, wb_ex, ertn_flush, trace_valid, trace_we;
    logic [4:0]  rf_waddr, trace_waddr;
    logic [31:0] rf_wdata, csr_wmask, csr_wdata, wb_vaddr, wb_pc, trace_pc, trace_wdata;
    logic [13:0] csr_num;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;

    pipe_wb_trace dut (
        .clk(clk), .resetn(resetn), .from_valid(fv), .to_allowin(to_allowin),
        .from_pc(cur.pc), .rf_we_MEM(cur.we), .rf_waddr_MEM(cur.waddr), .rf_wdata_MEM(cur.wdata),
        .csr_en_MEM(cur.cen), .csr_we_MEM(cur.cwe), .csr_num_MEM(cur.cnum),
        .csr_wmask_MEM(cur.cmask), .csr_wdata_MEM(cur.cdata), .ertn_MEM(cur.ertn),
        .rd_cnt_op_MEM(cur.cnt), .rd_timer_MEM(cur.timer), .exc_MEM(cur.exc),
        .vaddr_MEM(cur.vaddr), .csr_rvalue(crv),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .csr_we(csr_we),
        .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wdata(csr_wdata), .wb_ex(wb_ex),
        .ertn_flush(ertn_flush), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_vaddr(wb_vaddr), .wb_pc(wb_pc), .trace_valid(trace_valid), .trace_pop(pop),
        .trace_pc(trace_pc), .trace_wdata(trace_wdata), .trace_waddr(trace_waddr), .trace_we(trace_we)
    );

    int checks = 0, failures = 0;
    bit m_valid;
    tr_t q[$];
    int ecode_tbl[7] = '{'h0, 'h8, 'hB, 'hC, 'hD, 'h9, 'h8};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ins_t mk(input logic [31:0] pc, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        ins_t r = '{default: '0};
        r.pc = pc; r.we = we; r.waddr = wa; r.wdata = wd;
        return r;
    endfunction

    function automatic ins_t rnd();
        ins_t r;
        logic [2:0] ops[4] = '{3'b000, 3'b001, 3'b010, 3'b100};
        r.pc = $urandom; r.we = 1'($urandom); r.waddr = 5'($urandom); r.wdata = $urandom;
        r.cen = ($urandom % 4) == 0; r.cwe = 1'($urandom); r.cnum = 14'($urandom);
        r.cmask = $urandom; r.cdata = $urandom; r.ertn = ($urandom % 8) == 0;
        r.cnt = ops[$urandom % 4]; r.timer = $urandom;
        r.exc = ($urandom % 4) == 0 ? 7'($urandom) : 7'd0; r.vaddr = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        s = '{default: '0};
        q.delete();
    endtask

    task automatic drive(input ins_t i, input logic f, input logic p, input logic [31:0] c);
        @(negedge clk);
        cur = i; fv = f; pop = p; crv = c;
        #1;
    endtask

    // Compare every output with the model, then advance the model across the coming edge
    task automatic model();
        bit full, allow, ret, xany;
        int sel = -1;
        logic [31:0] wd;
        logic we_e;
        full  = q.size() == 4;
        allow = !m_valid || !full || pop;
        ret   = m_valid && (!full || pop);
        xany  = s.exc != 0;
        for (int i = 0; i < 7; i++) if (s.exc[i] && sel < 0) sel = i;
        wd   = (s.cen || s.cnt[0]) ? crv : (s.cnt[2:1] != 0) ? s.timer : s.wdata;
        we_e = ret && s.we && !xany;
        chk("to_allowin", to_allowin, allow);
        chk("rf_we", rf_we, we_e);
        chk("rf_waddr", rf_waddr, s.waddr);
        chk("rf_wdata", rf_wdata, wd);
        chk("csr_we", csr_we, ret && s.cwe && !xany);
        chk("csr_num", csr_num, s.cnum);
        chk("csr_wmask", csr_wmask, s.cmask);
        chk("csr_wdata", csr_wdata, s.cdata);
        chk("wb_ex", wb_ex, ret && xany);
        chk("ertn_flush", ertn_flush, ret && s.ertn && !xany);
        chk("wb_ecode", wb_ecode, sel < 0 ? 0 : ecode_tbl[sel]);
        chk("wb_esubcode", wb_esubcode, sel == 6);
        chk("wb_vaddr", wb_vaddr, s.vaddr);
        chk("wb_pc", wb_pc, s.pc);
        chk("trace_valid", trace_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("trace_pc", trace_pc, q[0].pc);
            chk("trace_we", trace_we, q[0].we);
            chk("trace_waddr", trace_waddr, q[0].waddr);
            chk("trace_wdata", trace_wdata, q[0].wdata);
        end
        if (pop && q.size() > 0) void'(q.pop_front());
        if (ret) q.push_back('{s.pc, we_e, s.waddr, wd});
        if (allow) begin
            m_valid = fv;
            if (fv) s = cur;
        end
    endtask

    task automatic cyc(input ins_t i, input logic f, input logic p);
        drive(i, f, p, $urandom);
        model();
    endtask

    initial begin
        ins_t t;
        cur = '{default: '0};
        model_reset();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        drive(cur, 1'b0, 1'b0, 32'h0);
        chk("reset_allowin", to_allowin, 1'b1);
        chk("reset_trace_valid", trace_valid, 1'b0);
        model();

        // plain add.w retire
        cyc(mk(32'h1C000000, 1'b1, 5'd5, 32'h1234), 1'b1, 1'b0);
        drive(mk(0, 0, 0, 0), 1'b0, 1'b0, 32'h0);
        chk("plain_rf_we", rf_we, 1'b1);
        chk("plain_rf_wdata", rf_wdata, 32'h1234);
        model();
        drive(mk(0, 0, 0, 0), 1'b0, 1'b0, 32'h0);
        chk("plain_head", {trace_pc, trace_we, trace_waddr, trace_wdata}, {32'h1C000000, 1'b1, 5'd5, 32'h1234});
        model();

        // exception priority
        t = mk(32'h1C000010, 1'b1, 5'd7, 32'h99); t.exc = 7'b0010110;
        cyc(t, 1'b1, 1'b1);
        drive(t, 1'b0, 1'b1, 32'h0);
        chk("prio_ecode", wb_ecode, 6'h8);
        chk("prio_ex", wb_ex, 1'b1);
        chk("prio_rf_we", rf_we, 1'b0);
        model();
        t.exc = 7'b1000000;
        cyc(t, 1'b1, 1'b1);
        drive(t, 1'b0, 1'b1, 32'h0);
        chk("adem_esub", wb_esubcode, 9'd1);
        model();

        // csr read, rdtimeh, ertn
        t = mk(32'h1C000020, 1'b1, 5'd3, 32'h0); t.cen = 1'b1;
        cyc(t, 1'b1, 1'b1);
        drive(t, 1'b0, 1'b1, 32'hABCD);
        chk("csrrd_wdata", rf_wdata, 32'hABCD);
        model();
        t = mk(32'h1C000024, 1'b1, 5'd4, 32'h0); t.cnt = 3'b100; t.timer = 32'h55;
        cyc(t, 1'b1, 1'b1);
        drive(t, 1'b0, 1'b1, 32'h0);
        chk("rdtimeh_wdata", rf_wdata, 32'h55);
        model();
        t = mk(32'h1C000028, 1'b0, 5'd0, 32'h0); t.ertn = 1'b1;
        cyc(t, 1'b1, 1'b1);
        cyc(t, 1'b0, 1'b1);
        cyc(t, 1'b0, 1'b1);

        // back-pressure, then full push+pop
        repeat (5) cyc(t, 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) cyc(mk(32'h1C001000 + 4 * k, 1'b1, 5'(k + 1), 32'(k * 17)), 1'b1, 1'b0);
        repeat (3) begin
            drive(mk(32'h1C001014, 1'b1, 5'd6, 32'd85), 1'b1, 1'b0, 32'h0);
            chk("bp_hold_allowin", to_allowin, 1'b0);
            chk("bp_hold_rf_we", rf_we, 1'b0);
            model();
        end
        drive(mk(32'h1C001014, 1'b1, 5'd6, 32'd85), 1'b1, 1'b1, 32'h0);
        chk("full_pp_rf_we", rf_we, 1'b1);
        chk("full_pp_wb_pc", wb_pc, 32'h1C001010);
        model();
        cyc(mk(0, 0, 0, 0), 1'b0, 1'b0);
        chk("full_pp_count", q.size(), 4);

        // async reset while stalled
        #2 resetn = 1'b0;
        #1;
        chk("arst_allowin", to_allowin, 1'b1);
        chk("arst_trace_valid", trace_valid, 1'b0);
        chk("arst_outs", {rf_we, rf_wdata, wb_pc, wb_ex, ertn_flush, csr_we, wb_ecode}, '0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        cyc(mk(0, 0, 0, 0), 1'b0, 1'b0);

        for (int n = 0; n < 1500; n++) cyc(rnd(), ($urandom % 4) != 0, 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
